// File: rtl/edge_drawer_if.sv
// Pixel-write port between the edge drawer and the framebuffer.
// The drawer is the master; the framebuffer answers with ready.
interface edge_drawer_if;
    logic       we;
    logic [6:0] x;
    logic [5:0] y;
    logic [2:0] data;
    logic       ready;

    modport master (output we, output x, output y, output data, input ready);
    modport slave  (input we, input x, input y, input data, output ready);
endinterface

// File: rtl/edge_drawer.sv
// Rasterises one axis-aligned square edge into pixel writes on a 128x64 grid.
// It pulses donedge when the edge is finished or skipped, then holds off for GUARD cycles.
module edge_drawer #(
    parameter int GUARD = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    etype,
    input  logic [6:0]    xstart,
    input  logic [6:0]    xend,
    input  logic [5:0]    ystart,
    input  logic [5:0]    yend,
    input  logic [2:0]    color,
    edge_drawer_if.master pix,
    output logic          donedge,
    output logic          busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_DRAW   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_GUARD  = 3'd5;

    localparam int            GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);

    logic [2:0]    state;
    logic [6:0]    cur_x;
    logic [6:0]    end_x;
    logic [5:0]    cur_y;
    logic [5:0]    end_y;
    logic [2:0]    edge_color;
    logic          vertical;
    logic [GW-1:0] guard_cnt;

    logic load_vert;
    logic load_horz;
    logic load_ok;

    assign load_vert = (etype == 3'b001);
    assign load_horz = (etype == 3'b010);
    assign load_ok   = (load_vert && (ystart <= yend)) || (load_horz && (xstart <= xend));

    // Only latched coordinates drive the cursor, so upstream changes after LOAD are harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            end_x      <= '0;
            end_y      <= '0;
            edge_color <= '0;
            vertical   <= 1'b0;
            guard_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (etype[1:0] != 2'b00) begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    cur_x      <= xstart;
                    cur_y      <= ystart;
                    end_x      <= xend;
                    end_y      <= yend;
                    edge_color <= color;
                    vertical   <= load_vert;
                    state      <= load_ok ? S_DRAW : S_DONE;
                end
                S_DRAW: begin
                    // Equality against the end coordinate stops the walk before any wrap at 127/63.
                    if (pix.ready) begin
                        if (vertical) begin
                            if (cur_y == end_y) begin
                                state <= S_DONE;
                            end else begin
                                cur_y <= cur_y + 6'd1;
                            end
                        end else begin
                            if (cur_x == end_x) begin
                                state <= S_DONE;
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    guard_cnt <= '0;
                    state     <= (GUARD == 0) ? S_IDLE : S_GUARD;
                end
                S_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign pix.we   = (state == S_DRAW);
    assign pix.x    = cur_x;
    assign pix.y    = cur_y;
    assign pix.data = edge_color;
    assign donedge  = (state == S_DONE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_edge_drawer.sv
// Directed self-checking bench for edge_drawer: reset, vertical, horizontal,
// skipped edges, backpressure and a four-edge square driven by an edge-calculator model.
module tb_edge_drawer;

    localparam int GUARD = 2;
    localparam int LIMIT = 300;

    logic       clock;
    logic       reset;
    logic [2:0] etype;
    logic [6:0] xstart;
    logic [6:0] xend;
    logic [5:0] ystart;
    logic [5:0] yend;
    logic [2:0] color;
    logic       donedge;
    logic       busy;

    edge_drawer_if pix ();

    edge_drawer #(.GUARD(GUARD)) dut (
        .clock   (clock),
        .reset   (reset),
        .etype   (etype),
        .xstart  (xstart),
        .xend    (xend),
        .ystart  (ystart),
        .yend    (yend),
        .color   (color),
        .pix     (pix),
        .donedge (donedge),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks;
    int n_pass;

    logic [6:0] wx [0:LIMIT-1];
    logic [5:0] wy [0:LIMIT-1];
    logic [2:0] wd [0:LIMIT-1];
    int         wc [0:LIMIT-1];
    int         n_we;
    int         n_done;
    int         done_cyc;
    int         busy_bad;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cycle 0 is the first IDLE cycle with the edge presented; returns at the next edge's cycle 0.
    // On donedge the upstream model switches etype at once and the coordinates one cycle later.
    task automatic drive_edge(input logic [2:0] et, input logic [6:0] xs, input logic [6:0] xe,
                              input logic [5:0] ys, input logic [5:0] ye, input logic [2:0] col,
                              input logic [255:0] stall, input bit has_next, input logic [2:0] nx_et,
                              input logic [6:0] nx_xs, input logic [6:0] nx_xe, input logic [5:0] nx_ys,
                              input logic [5:0] nx_ye, input logic [2:0] nx_col);
        int c;
        etype  = et;
        xstart = xs;
        xend   = xe;
        ystart = ys;
        yend   = ye;
        color  = col;
        n_we = 0;
        n_done = 0;
        done_cyc = -1;
        busy_bad = 0;
        c = 0;
        forever begin
            pix.ready = (c < 256) ? ~stall[c] : 1'b1;
            if (pix.we) begin
                if (n_we < LIMIT) begin
                    wx[n_we] = pix.x;
                    wy[n_we] = pix.y;
                    wd[n_we] = pix.data;
                    wc[n_we] = c;
                end
                n_we++;
            end
            if ((c == 0) == busy) busy_bad++;
            if (donedge) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    etype = has_next ? nx_et : 3'b000;
                end
            end
            if (has_next && done_cyc >= 0 && c == done_cyc + 1) begin
                xstart = nx_xs;
                xend   = nx_xe;
                ystart = nx_ys;
                yend   = nx_ye;
                color  = nx_col;
            end
            if ((done_cyc >= 0 && c == done_cyc + GUARD) || c >= LIMIT) begin
                tick();
                break;
            end
            tick();
            c++;
        end
        pix.ready = 1'b1;
    endtask

    task automatic run_edge(input logic [2:0] et, input logic [6:0] xs, input logic [6:0] xe,
                            input logic [5:0] ys, input logic [5:0] ye, input logic [2:0] col,
                            input logic [255:0] stall);
        drive_edge(et, xs, xe, ys, ye, col, stall, 1'b0, 3'b000, 7'd0, 7'd0, 6'd0, 6'd0, 3'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        etype = 3'b000;
        xstart = '0; xend = '0; ystart = '0; yend = '0; color = '0;
        pix.ready = 1'b1;
        repeat (2) tick();
        n_checks++; if (pix.we !== 1'b0)    $display("[TB] FAIL reset_we: got %b expected 0", pix.we);      else n_pass++;
        n_checks++; if (pix.x !== 7'd0)     $display("[TB] FAIL reset_x: got %0d expected 0", pix.x);       else n_pass++;
        n_checks++; if (pix.y !== 6'd0)     $display("[TB] FAIL reset_y: got %0d expected 0", pix.y);       else n_pass++;
        n_checks++; if (pix.data !== 3'd0)  $display("[TB] FAIL reset_data: got %0d expected 0", pix.data); else n_pass++;
        n_checks++; if (donedge !== 1'b0)   $display("[TB] FAIL reset_donedge: got %b expected 0", donedge); else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("[TB] FAIL reset_busy: got %b expected 0", busy);      else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vertical();
        run_edge(3'b001, 7'd5, 7'd5, 6'd10, 6'd13, 3'd3, '0);
        n_checks++; if (n_we !== 4) $display("[TB] FAIL vert_count: got %0d expected 4", n_we); else n_pass++;
        for (int i = 0; i < 4 && i < n_we; i++) begin
            n_checks++;
            if ({wx[i], wy[i], wd[i]} !== {7'd5, 6'(10 + i), 3'd3} || wc[i] !== 3 + i)
                $display("[TB] FAIL vert_pixel%0d: got (%0d,%0d) data %0d cycle %0d expected (5,%0d) data 3 cycle %0d",
                         i, wx[i], wy[i], wd[i], wc[i], 10 + i, 3 + i);
            else n_pass++;
        end
        n_checks++; if (done_cyc !== 7) $display("[TB] FAIL vert_done_cycle: got %0d expected 7", done_cyc); else n_pass++;
        n_checks++; if (n_done !== 1)   $display("[TB] FAIL vert_done_count: got %0d expected 1", n_done); else n_pass++;
        n_checks++; if (busy_bad !== 0) $display("[TB] FAIL vert_busy: got %0d bad cycles expected 0", busy_bad); else n_pass++;
    endtask

    task automatic test_horizontal_full();
        int bad;
        run_edge(3'b010, 7'd0, 7'd127, 6'd63, 6'd63, 3'd6, '0);
        n_checks++; if (n_we !== 128) $display("[TB] FAIL horiz_count: got %0d expected 128", n_we); else n_pass++;
        bad = 0;
        for (int i = 0; i < 128 && i < n_we; i++) begin
            if (int'(wx[i]) != i || wy[i] !== 6'd63 || wd[i] !== 3'd6 || wc[i] != 3 + i) bad++;
        end
        n_checks++; if (bad !== 0)       $display("[TB] FAIL horiz_pixels: got %0d wrong pixels expected 0", bad); else n_pass++;
        n_checks++; if (done_cyc !== 131) $display("[TB] FAIL horiz_done_cycle: got %0d expected 131", done_cyc); else n_pass++;
        n_checks++; if (n_done !== 1)     $display("[TB] FAIL horiz_done_count: got %0d expected 1", n_done); else n_pass++;
    endtask

    task automatic test_invalid();
        logic [2:0] ets [0:3];
        logic [6:0] xss [0:3];
        logic [6:0] xes [0:3];
        logic [5:0] yss [0:3];
        logic [5:0] yes [0:3];
        ets = '{3'b101, 3'b010, 3'b001, 3'b011};
        xss = '{7'd9,   7'd40,  7'd12,  7'd1};
        xes = '{7'd30,  7'd39,  7'd12,  7'd4};
        yss = '{6'd2,   6'd8,   6'd20,  6'd1};
        yes = '{6'd9,   6'd8,   6'd19,  6'd1};
        for (int k = 0; k < 4; k++) begin
            run_edge(ets[k], xss[k], xes[k], yss[k], yes[k], 3'd7, '0);
            n_checks++; if (n_we !== 0)     $display("[TB] FAIL skip%0d_writes: got %0d expected 0", k, n_we); else n_pass++;
            n_checks++; if (done_cyc !== 3) $display("[TB] FAIL skip%0d_done_cycle: got %0d expected 3", k, done_cyc); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] stall;
        int           exp_x [0:4];
        stall = '0;
        stall[3] = 1'b1;
        stall[5] = 1'b1;
        exp_x = '{20, 20, 21, 21, 22};
        run_edge(3'b010, 7'd20, 7'd22, 6'd7, 6'd7, 3'd2, stall);
        n_checks++; if (n_we !== 5) $display("[TB] FAIL bp_we_cycles: got %0d expected 5", n_we); else n_pass++;
        for (int i = 0; i < 5 && i < n_we; i++) begin
            n_checks++;
            if (int'(wx[i]) != exp_x[i] || wy[i] !== 6'd7 || wc[i] != 3 + i)
                $display("[TB] FAIL bp_write%0d: got (%0d,%0d) cycle %0d expected (%0d,7) cycle %0d",
                         i, wx[i], wy[i], wc[i], exp_x[i], 3 + i);
            else n_pass++;
        end
        n_checks++; if (done_cyc !== 8) $display("[TB] FAIL bp_done_cycle: got %0d expected 8", done_cyc); else n_pass++;
    endtask

    // Square of side depth=53 centred on (64,32): x 38..90, y 6..58; left, right, top, bottom.
    task automatic test_sequence();
        logic [2:0] ets [0:4];
        logic [6:0] xss [0:4];
        logic [6:0] xes [0:4];
        logic [5:0] yss [0:4];
        logic [5:0] yes [0:4];
        logic [2:0] cols [0:4];
        int bad;
        ets  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b000};
        xss  = '{7'd38,  7'd90,  7'd38,  7'd38,  7'd0};
        xes  = '{7'd38,  7'd90,  7'd90,  7'd90,  7'd0};
        yss  = '{6'd6,   6'd6,   6'd6,   6'd58,  6'd0};
        yes  = '{6'd58,  6'd58,  6'd6,   6'd58,  6'd0};
        cols = '{3'd1,   3'd2,   3'd4,   3'd7,   3'd0};
        for (int k = 0; k < 4; k++) begin
            drive_edge(ets[k], xss[k], xes[k], yss[k], yes[k], cols[k], '0, 1'b1,
                       ets[k+1], xss[k+1], xes[k+1], yss[k+1], yes[k+1], cols[k+1]);
            n_checks++; if (n_we !== 53) $display("[TB] FAIL seq%0d_count: got %0d expected 53", k, n_we); else n_pass++;
            bad = 0;
            for (int i = 0; i < 53 && i < n_we; i++) begin
                if (ets[k] == 3'b001) begin
                    if (wx[i] !== xss[k] || int'(wy[i]) != int'(yss[k]) + i) bad++;
                end else begin
                    if (int'(wx[i]) != int'(xss[k]) + i || wy[i] !== yss[k]) bad++;
                end
                if (wd[i] !== cols[k] || wc[i] != 3 + i) bad++;
            end
            n_checks++; if (bad !== 0)       $display("[TB] FAIL seq%0d_pixels: got %0d wrong pixels expected 0", k, bad); else n_pass++;
            n_checks++; if (done_cyc !== 56) $display("[TB] FAIL seq%0d_done_cycle: got %0d expected 56", k, done_cyc); else n_pass++;
            n_checks++; if (busy_bad !== 0)  $display("[TB] FAIL seq%0d_busy: got %0d bad cycles expected 0", k, busy_bad); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_draw();
        int n_late;
        etype = 3'b001; xstart = 7'd3; xend = 7'd3; ystart = 6'd0; yend = 6'd40; color = 3'd5;
        pix.ready = 1'b1;
        repeat (5) tick();
        n_checks++; if (pix.we !== 1'b1) $display("[TB] FAIL mid_draw_active: got %b expected 1", pix.we); else n_pass++;
        reset = 1'b1;
        etype = 3'b000;
        repeat (2) tick();
        reset = 1'b0;
        n_checks++; if (pix.we !== 1'b0)   $display("[TB] FAIL rst_mid_we: got %b expected 0", pix.we);      else n_pass++;
        n_checks++; if (pix.x !== 7'd0)    $display("[TB] FAIL rst_mid_x: got %0d expected 0", pix.x);       else n_pass++;
        n_checks++; if (pix.y !== 6'd0)    $display("[TB] FAIL rst_mid_y: got %0d expected 0", pix.y);       else n_pass++;
        n_checks++; if (pix.data !== 3'd0) $display("[TB] FAIL rst_mid_data: got %0d expected 0", pix.data); else n_pass++;
        n_checks++; if (donedge !== 1'b0)  $display("[TB] FAIL rst_mid_donedge: got %b expected 0", donedge); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy);      else n_pass++;
        n_late = 0;
        repeat (10) begin
            if (pix.we || donedge) n_late++;
            tick();
        end
        n_checks++; if (n_late !== 0) $display("[TB] FAIL rst_mid_quiet: got %0d active cycles expected 0", n_late); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_vertical();
        test_horizontal_full();
        test_invalid();
        test_backpressure();
        test_sequence();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
